// File: rtl/adc_pipe_if.sv
// ---------------------------------------------------------------------------
// adc_pipe_if
// Purpose : Bundles the operand-side and result-side valid/ready handshakes of
//           the pipelined add/subtract-with-carry unit.
// Signals : in_valid/in_ready, a, b, c0, sub   operand beat (upstream -> unit)
//           out_valid/out_ready, s, ovf, zero  result beat (unit -> downstream)
// Modports: slave  - the arithmetic unit itself
//           master - whoever drives operands and consumes results
// ---------------------------------------------------------------------------
interface adc_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c0;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, c0, sub, out_ready,
    output in_ready, out_valid, s, ovf, zero
  );

  modport master (
    output in_valid, a, b, c0, sub, out_ready,
    input  in_ready, out_valid, s, ovf, zero
  );
endinterface

// File: rtl/adc_pipe.sv
// ---------------------------------------------------------------------------
// adc_pipe
// Purpose : Pipelined add/subtract-with-carry. Computes a + b + c0 or
//           a - b - c0, splitting the WIDTH-bit carry chain into STAGES equal
//           chunks so that each clock resolves one chunk of the sum.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    adc_pipe_if.slave
//                    in_valid/in_ready/a/b/c0/sub   operand beat
//                    out_valid/out_ready            result handshake
//                    s[WIDTH]   final carry (sub: 1 = no borrow)
//                    s[W-1:0]   sum
//                    ovf        signed overflow
//                    zero       sum is all zeros
// Latency : STAGES cycles (result visible after edge N+STAGES-1 for a beat
//           accepted at edge N); throughput one beat per cycle.
// ---------------------------------------------------------------------------
module adc_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       rst_n,
  adc_pipe_if.slave bus
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registered state: valid bit, forwarded operands, partial sum
  // with the chunks resolved so far, and the carry into the next chunk.
  logic             validQ [STAGES];
  logic             validD [STAGES];
  logic [WIDTH-1:0] aQ     [STAGES];
  logic [WIDTH-1:0] aD     [STAGES];
  logic [WIDTH-1:0] bQ     [STAGES];
  logic [WIDTH-1:0] bD     [STAGES];
  logic [WIDTH-1:0] sumQ   [STAGES];
  logic [WIDTH-1:0] sumD   [STAGES];
  logic             carryQ [STAGES];
  logic             carryD [STAGES];
  logic             ovfQ;
  logic             ovfD;
  logic             zeroQ;
  logic             zeroD;

  // What each stage sees as its input: stage 0 sees the prepared operands,
  // every later stage sees the registers of the stage before it.
  logic             srcValid [STAGES];
  logic [WIDTH-1:0] srcA     [STAGES];
  logic [WIDTH-1:0] srcB     [STAGES];
  logic [WIDTH-1:0] srcSum   [STAGES];
  logic             srcCarry [STAGES];
  logic [CW:0]      chunk;

  logic adv;

  // The whole pipe moves as one: it advances whenever the output slot is
  // empty or being drained, and otherwise every stage holds.
  assign adv = ~validQ[LAST] | bus.out_ready;

  // Operand prep folds subtraction into addition (a + ~b + ~c0), then each
  // stage resolves its own chunk of the carry chain and forwards the rest.
  // Flags are derived from the final stage's sum as it is being registered.
  always_comb begin
    srcValid[0] = bus.in_valid;
    srcA[0]     = bus.a;
    srcB[0]     = bus.sub ? ~bus.b : bus.b;
    srcSum[0]   = '0;
    srcCarry[0] = bus.c0 ^ bus.sub;
    for (int k = 1; k < STAGES; k++) begin
      srcValid[k] = validQ[k-1];
      srcA[k]     = aQ[k-1];
      srcB[k]     = bQ[k-1];
      srcSum[k]   = sumQ[k-1];
      srcCarry[k] = carryQ[k-1];
    end

    chunk = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, srcA[k][k*CW +: CW]}
            + {1'b0, srcB[k][k*CW +: CW]}
            + {{CW{1'b0}}, srcCarry[k]};
      validD[k]              = srcValid[k];
      aD[k]                  = srcA[k];
      bD[k]                  = srcB[k];
      sumD[k]                = srcSum[k];
      sumD[k][k*CW +: CW]    = chunk[CW-1:0];
      carryD[k]              = chunk[CW];
    end

    ovfD  = (srcA[LAST][WIDTH-1] == srcB[LAST][WIDTH-1]) &
            (sumD[LAST][WIDTH-1] != srcA[LAST][WIDTH-1]);
    zeroD = ~|sumD[LAST];
  end

  // Pipeline registers. Reset clears every stage so in-flight beats vanish
  // and the visible result reads as zero; otherwise shift on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        validQ[k] <= 1'b0;
        aQ[k]     <= '0;
        bQ[k]     <= '0;
        sumQ[k]   <= '0;
        carryQ[k] <= 1'b0;
      end
      ovfQ  <= 1'b0;
      zeroQ <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        validQ[k] <= validD[k];
        aQ[k]     <= aD[k];
        bQ[k]     <= bD[k];
        sumQ[k]   <= sumD[k];
        carryQ[k] <= carryD[k];
      end
      ovfQ  <= ovfD;
      zeroQ <= zeroD;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = validQ[LAST];
  assign bus.s         = {carryQ[LAST], sumQ[LAST]};
  assign bus.ovf       = ovfQ;
  assign bus.zero      = zeroQ;

endmodule
